// File: rtl/phy_rx_packer_if.sv
// Write side of the per-PHY receive FIFO: 18-bit word, write strobe and full flag.
interface phy_rx_packer_if;
  logic [17:0] phy_din;
  logic        phy_wr_en;
  logic        phy_full;

  modport master (output phy_din, output phy_wr_en, input phy_full);
  modport slave  (input phy_din, input phy_wr_en, output phy_full);
endinterface

// File: rtl/phy_rx_packer.sv
// Packs a GMII receive stream into 18-bit FIFO words: data pairs, one status word,
// then four timestamp words per frame; counts completed and dropped frames.
module phy_rx_packer #(
  parameter logic [11:0] RUNT_LEN = 12'd60,
  parameter logic [11:0] MAX_LEN  = 12'd4095
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [63:0]           global_counter,
  input  logic [7:0]            gmii_rxd,
  input  logic                  gmii_rx_dv,
  input  logic                  gmii_rx_er,
  phy_rx_packer_if.master       fifo,
  output logic [7:0]            phy_rx_count,
  output logic [7:0]            phy_drop_count
);

  typedef enum logic [2:0] {
    S_SYNC, S_IDLE, S_PREAMBLE, S_DATA, S_STATUS, S_TS, S_DROP
  } state_t;

  state_t      state_q, state_d;
  logic        dv_q;
  logic [63:0] ts_q, ts_d;
  logic [11:0] len_q, len_d;
  logic        oversize_q, oversize_d;
  logic        overflow_q, overflow_d;
  logic        rx_er_q, rx_er_d;
  logic        half_q, half_d;
  logic [7:0]  b0_q, b0_d;
  logic [1:0]  ts_idx_q, ts_idx_d;
  logic        dropping_q, dropping_d;
  logic        count_pend_q, count_pend_d;
  logic [7:0]  rx_count_q, rx_count_d;
  logic [7:0]  drop_count_q, drop_count_d;
  logic [17:0] din_q, din_d;
  logic        wr_q, wr_d;
  logic        rise, in_trailer;

  assign rise       = gmii_rx_dv & ~dv_q;
  assign in_trailer = (state_q == S_STATUS) || (state_q == S_TS);

  always_comb begin
    state_d      = state_q;
    ts_d         = ts_q;
    len_d        = len_q;
    oversize_d   = oversize_q;
    overflow_d   = overflow_q;
    rx_er_d      = rx_er_q;
    half_d       = half_q;
    b0_d         = b0_q;
    ts_idx_d     = ts_idx_q;
    count_pend_d = 1'b0;
    rx_count_d   = rx_count_q + {7'd0, count_pend_q};
    drop_count_d = drop_count_q;
    din_d        = din_q;
    wr_d         = 1'b0;

    // A frame starting while the trailer is still pending is discarded whole;
    // its bytes are ignored until dv falls.
    if (in_trailer && rise) drop_count_d = drop_count_q + 8'd1;
    dropping_d = gmii_rx_dv & (dropping_q | (in_trailer & rise));

    case (state_q)
      S_SYNC: if (!gmii_rx_dv) state_d = S_IDLE;
      S_IDLE: if (gmii_rx_dv) state_d = S_PREAMBLE;
      S_PREAMBLE: begin
        if (!gmii_rx_dv) begin
          state_d = S_IDLE;
        end else if (gmii_rxd == 8'hD5) begin
          ts_d       = global_counter;
          len_d      = '0;
          oversize_d = 1'b0;
          overflow_d = 1'b0;
          rx_er_d    = 1'b0;
          half_d     = 1'b0;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        if (gmii_rx_dv) begin
          if (gmii_rx_er) rx_er_d = 1'b1;
          if (len_q == MAX_LEN) begin
            oversize_d = 1'b1;
          end else begin
            len_d = len_q + 12'd1;
            if (!half_q) begin
              b0_d   = gmii_rxd;
              half_d = 1'b1;
            end else begin
              half_d = 1'b0;
              if (!overflow_q) begin
                if (fifo.phy_full) begin
                  overflow_d = 1'b1;
                end else begin
                  wr_d  = 1'b1;
                  din_d = {2'b00, b0_q, gmii_rxd};
                end
              end
            end
          end
        end else begin
          if (half_q && !overflow_q) begin
            if (fifo.phy_full) begin
              overflow_d = 1'b1;
            end else begin
              wr_d  = 1'b1;
              din_d = {2'b00, b0_q, 8'h00};
            end
          end
          half_d  = 1'b0;
          state_d = S_STATUS;
        end
      end
      S_STATUS: begin
        if (!fifo.phy_full) begin
          wr_d     = 1'b1;
          din_d    = {2'b10, oversize_q, overflow_q, rx_er_q, (len_q < RUNT_LEN), len_q};
          ts_idx_d = 2'd0;
          state_d  = S_TS;
        end
      end
      S_TS: begin
        if (!fifo.phy_full) begin
          wr_d = 1'b1;
          case (ts_idx_q)
            2'd0:    din_d = {2'b11, ts_q[63:48]};
            2'd1:    din_d = {2'b11, ts_q[47:32]};
            2'd2:    din_d = {2'b11, ts_q[31:16]};
            default: din_d = {2'b11, ts_q[15:0]};
          endcase
          ts_idx_d = ts_idx_q + 2'd1;
          if (ts_idx_q == 2'd3) begin
            count_pend_d = 1'b1;
            state_d      = dropping_d ? S_DROP : S_IDLE;
          end
        end
      end
      S_DROP: if (!gmii_rx_dv) state_d = S_IDLE;
      default: state_d = S_SYNC;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= S_SYNC;
      dv_q         <= 1'b0;
      ts_q         <= '0;
      len_q        <= '0;
      oversize_q   <= 1'b0;
      overflow_q   <= 1'b0;
      rx_er_q      <= 1'b0;
      half_q       <= 1'b0;
      b0_q         <= '0;
      ts_idx_q     <= '0;
      dropping_q   <= 1'b0;
      count_pend_q <= 1'b0;
      rx_count_q   <= '0;
      drop_count_q <= '0;
      din_q        <= '0;
      wr_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      dv_q         <= gmii_rx_dv;
      ts_q         <= ts_d;
      len_q        <= len_d;
      oversize_q   <= oversize_d;
      overflow_q   <= overflow_d;
      rx_er_q      <= rx_er_d;
      half_q       <= half_d;
      b0_q         <= b0_d;
      ts_idx_q     <= ts_idx_d;
      dropping_q   <= dropping_d;
      count_pend_q <= count_pend_d;
      rx_count_q   <= rx_count_d;
      drop_count_q <= drop_count_d;
      din_q        <= din_d;
      wr_q         <= wr_d;
    end
  end

  assign fifo.phy_din    = din_q;
  assign fifo.phy_wr_en  = wr_q;
  assign phy_rx_count    = rx_count_q;
  assign phy_drop_count  = drop_count_q;

endmodule

// File: tb/tb_phy_rx_packer.sv
// Bench for phy_rx_packer: frame-level model builds the expected word stream,
// a negedge compare process checks every write and the frame counter.
module tb_phy_rx_packer;

  localparam int RUNT = 60;
  localparam int MAXL = 4095;
  localparam logic [63:0] GC_STEP = 64'h0001_0001_0001_0001;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic [63:0] gc;
  logic [7:0]  rxd;
  logic        rx_dv, rx_er;
  logic [7:0]  rx_count, drop_count;

  phy_rx_packer_if ifc ();

  phy_rx_packer #(.RUNT_LEN(12'd60), .MAX_LEN(12'd4095)) dut (
    .sys_clk        (clk),
    .sys_rst        (sys_rst),
    .global_counter (gc),
    .gmii_rxd       (rxd),
    .gmii_rx_dv     (rx_dv),
    .gmii_rx_er     (rx_er),
    .fifo           (ifc.master),
    .phy_rx_count   (rx_count),
    .phy_drop_count (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [17:0] w; logic last; } exp_t;
  exp_t q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic full_prev = 1'b0;

  int exp_rx = 0;
  int pend   = 0;
  int data_seen = 0, frame_data = 0;
  int first_data_cyc = 0, status_cyc = 0;
  int sfd_cyc = 0, dvlow_cyc = 0;
  logic [17:0] first_word = '0, last_data = '0, last_status = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    full_prev = ifc.phy_full;
  end

  always @(negedge clk) begin
    exp_t e;
    if (sys_rst) begin
      exp_rx = 0;
      pend = 0;
      data_seen = 0;
      check("wr_in_reset", 64'(ifc.phy_wr_en), 64'd0);
    end else begin
      exp_rx = (exp_rx + pend) % 256;
      pend = 0;
      check("rx_count", 64'(rx_count), 64'(exp_rx));
      if (ifc.phy_wr_en) begin
        check("write_when_full", 64'(full_prev), 64'd0);
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_word actual=%0h required=none", ifc.phy_din);
        end else begin
          e = q.pop_front();
          check("word", 64'(ifc.phy_din), 64'(e.w));
          if (e.w[17:16] == 2'b00) begin
            data_seen++;
            if (data_seen == 1) begin
              first_data_cyc = cyc;
              first_word = ifc.phy_din;
            end
            last_data = ifc.phy_din;
          end else if (e.w[17:16] == 2'b10) begin
            last_status = ifc.phy_din;
            status_cyc = cyc;
            frame_data = data_seen;
            data_seen = 0;
          end
          if (e.last) pend = 1;
        end
      end
    end
  end

  function automatic logic [7:0] fbyte(input logic [7:0] seed, input int t);
    return seed + t[7:0];
  endfunction

  // Expected words of one frame from its byte count, error flag, and the byte
  // position at which the FIFO went full (-1: never).
  task automatic push_frame(input int n, input logic [7:0] seed, input bit er,
                            input int full_at, input logic [63:0] ts);
    int stored, nw, due;
    bit ovf;
    logic [7:0] b1;
    logic [11:0] len;
    stored = (n > MAXL) ? MAXL : n;
    len = 12'(stored);
    nw = (stored + 1) / 2;
    ovf = 1'b0;
    for (int k = 0; k < nw; k++) begin
      due = (2*k + 1 <= stored - 1) ? 2*k + 1 : n;
      if (full_at >= 0 && due >= full_at) ovf = 1'b1;
      else begin
        b1 = (2*k + 1 < stored) ? fbyte(seed, 2*k + 1) : 8'h00;
        q.push_back('{w: {2'b00, fbyte(seed, 2*k), b1}, last: 1'b0});
      end
    end
    q.push_back('{w: {2'b10, (n > MAXL), ovf, er, (stored < RUNT), len}, last: 1'b0});
    q.push_back('{w: {2'b11, ts[63:48]}, last: 1'b0});
    q.push_back('{w: {2'b11, ts[47:32]}, last: 1'b0});
    q.push_back('{w: {2'b11, ts[31:16]}, last: 1'b0});
    q.push_back('{w: {2'b11, ts[15:0]},  last: 1'b1});
  endtask

  task automatic tick(input bit dv, input logic [7:0] d, input bit er, input bit f);
    @(posedge clk);
    #2;
    gc = gc + GC_STEP;
    rx_dv = dv;
    rxd = d;
    rx_er = er;
    ifc.phy_full = f;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 8'h00, 1'b0, ifc.phy_full);
  endtask

  task automatic send_frame(input int n, input logic [7:0] seed, input int er_at,
                            input int full_at, input int hold, input bit expect_it);
    bit f;
    repeat (7) tick(1'b1, 8'h55, 1'b0, 1'b0);
    tick(1'b1, 8'hD5, 1'b0, 1'b0);
    sfd_cyc = cyc;
    if (expect_it) push_frame(n, seed, (er_at >= 0), full_at, gc);
    for (int t = 0; t < n; t++) begin
      f = (full_at >= 0) && (t >= full_at);
      tick(1'b1, fbyte(seed, t), (t == er_at), f);
    end
    f = (full_at >= 0) && (n >= full_at);
    tick(1'b0, 8'h00, 1'b0, f);
    dvlow_cyc = cyc;
    if (hold >= 0) begin
      repeat (hold) tick(1'b0, 8'h00, 1'b0, f);
      tick(1'b0, 8'h00, 1'b0, 1'b0);
    end
  endtask

  initial begin
    sys_rst = 1'b1;
    gc = 64'h1122_3344_5566_7788;
    rxd = 8'h00;
    rx_dv = 1'b0;
    rx_er = 1'b0;
    ifc.phy_full = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_din", 64'(ifc.phy_din), 64'h0);
    check("rst_wr", 64'(ifc.phy_wr_en), 64'h0);
    check("rst_rx_count", 64'(rx_count), 64'h0);
    check("rst_drop_count", 64'(drop_count), 64'h0);
    @(posedge clk);
    #2;
    sys_rst = 1'b0;
    idle(5);

    // 64-byte frame, bytes 00..3F
    send_frame(64, 8'h00, -1, -1, 0, 1'b1);
    idle(20);
    check("f64_first_word", 64'(first_word), 64'h00001);
    check("f64_last_data", 64'(last_data), 64'h03E3F);
    check("f64_status", 64'(last_status), 64'h20040);
    check("f64_data_words", 64'(frame_data), 64'd32);
    check("f64_first_latency", 64'(first_data_cyc - sfd_cyc), 64'd3);
    check("f64_status_latency", 64'(status_cyc - dvlow_cyc), 64'd2);
    check("f64_rx_count", 64'(rx_count), 64'd1);

    // odd length, not runt
    send_frame(61, 8'h00, -1, -1, 0, 1'b1);
    idle(20);
    check("f61_last_data", 64'(last_data), 64'h03C00);
    check("f61_status", 64'(last_status), 64'h2003D);
    check("f61_data_words", 64'(frame_data), 64'd31);
    check("f61_status_latency", 64'(status_cyc - dvlow_cyc), 64'd2);

    // runt
    send_frame(59, 8'h00, -1, -1, 0, 1'b1);
    idle(20);
    check("f59_status", 64'(last_status), 64'h2103B);

    // FIFO full from the 10th data word, held into the trailer
    send_frame(64, 8'h10, -1, 19, 6, 1'b1);
    idle(20);
    check("ovf_status", 64'(last_status), 64'h24040);
    check("ovf_data_words", 64'(frame_data), 64'd9);

    // receive error on one byte
    send_frame(64, 8'h20, 30, -1, 0, 1'b1);
    idle(20);
    check("rxer_status", 64'(last_status), 64'h22040);

    // oversize
    send_frame(5000, 8'h07, -1, -1, 0, 1'b1);
    idle(20);
    check("big_status", 64'(last_status), 64'h28FFF);
    check("big_data_words", 64'(frame_data), 64'd2048);
    check("rx_count_6", 64'(rx_count), 64'd6);

    // second frame arrives while the first trailer is stalled by full
    send_frame(20, 8'hA0, -1, 20, -1, 1'b1);
    idle(12);
    repeat (2) tick(1'b1, 8'h55, 1'b0, 1'b1);
    repeat (5) tick(1'b1, 8'h55, 1'b0, 1'b0);
    tick(1'b1, 8'hD5, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) tick(1'b1, 8'(i), 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    idle(20);
    check("drop_status", 64'(last_status), 64'h21014);
    check("drop_data_words", 64'(frame_data), 64'd10);
    check("drop_count", 64'(drop_count), 64'd1);
    check("rx_count_7", 64'(rx_count), 64'd7);

    // reset released mid-frame: that frame is ignored, the next is captured
    check("queue_empty_pre_reset", 64'(q.size()), 64'd0);
    sys_rst = 1'b1;
    idle(3);
    repeat (7) tick(1'b1, 8'h55, 1'b0, 1'b0);
    tick(1'b1, 8'hD5, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tick(1'b1, 8'(i), 1'b0, 1'b0);
    sys_rst = 1'b0;
    for (int i = 10; i < 40; i++) tick(1'b1, 8'(i), 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    idle(12);
    send_frame(64, 8'h33, -1, -1, 0, 1'b1);
    idle(20);
    check("post_reset_status", 64'(last_status), 64'h20040);
    check("post_reset_rx_count", 64'(rx_count), 64'd1);
    check("post_reset_drop_count", 64'(drop_count), 64'd0);

    check("queue_empty_end", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
